lif_pe: RTL and testbench
=========================

# lif_pe

Parametrised leaky integrate-and-fire processing element: the next-generation neuron of the SNN array. It accepts one timestep of N_IN input spikes per handshake and serially accumulates the signed weight of each active synapse into a saturating membrane potential. It then applies a shift-based leak, fires against a threshold, and enforces a refractory period. The spike result is returned over a valid/ready handshake to the layer controller.

## Interface
- N_IN, 8: number of input synapses (≥2)
- W_WIDTH, 8: signed weight width
- V_WIDTH, 12: signed membrane-potential width (> W_WIDTH)
- THRESHOLD, 20: fire when potential > THRESHOLD (signed, must fit V_WIDTH)
- LEAK_SHIFT, 3: leak = potential >>> LEAK_SHIFT; 0 disables leak
- REFRACT, 2: timesteps ignored after a spike; 0 disables
- clock  in  1  single clock, all logic posedge
- reset  in  1  synchronous, active-high
- weight_w_en  in  1  write weight_in to weight_addr
- weight_addr  in  $clog2(N_IN)  synapse index
- weight_in  in  W_WIDTH  signed weight
- step_valid  in  1  timestep input offered
- step_ready  out  1  PE idle, can accept a timestep
- in_spikes  in  N_IN  bit i = synapse i spiked this timestep
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_spike  out  1  neuron fired this timestep (valid with out_valid)
- memb_pot  out  V_WIDTH  current membrane potential (debug/observe)

## Operation
- FSM states IDLE, ACCUM, LEAK, OUT; reset → IDLE.
- IDLE: step_ready=1. On step_valid: latch in_spikes, set idx=0, go to ACCUM.
- ACCUM: exactly N_IN cycles, idx 0..N_IN-1.
  - If latched bit idx=1 and ref_cnt==0: v ← sat(v + sext(w[idx])).
  - After idx=N_IN-1, go to LEAK.
  - Refractory steps still take N_IN cycles (fixed latency) but add nothing.
- LEAK: v' = (LEAK_SHIFT==0) ? v : v − (v >>> LEAK_SHIFT), arithmetic shift.
  - If v' > THRESHOLD (signed): spike=1, v←0, ref_cnt←REFRACT.
  - Else: spike=0, v←v', ref_cnt←ref_cnt−1 if nonzero.
  - Go to OUT.
- OUT: out_valid=1 with out_spike held stable until out_ready. On the handshake cycle, go to IDLE.
- Saturation: sums clamp to [−2^(V_WIDTH−1), 2^(V_WIDTH−1)−1]. No wrap-around is permitted.
- Weight writes are accepted in every state. Same-cycle write and accumulate on the same index: the accumulation uses the old weight; the new value is visible the next cycle.
- step_valid outside IDLE is ignored; the source must hold it until step_ready.
- Reset values: all weights 0, v=0, ref_cnt=0, out_valid=0, out_spike=0, state IDLE. step_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation: the in-flight timestep is discarded, with no out_valid produced.

## Timing
- Handshake at cycle 0 (step_valid & step_ready). ACCUM runs cycles 1..N_IN, LEAK runs cycle N_IN+1, and out_valid rises at cycle N_IN+2.
- Minimum step-to-step period is N_IN+3 cycles with out_ready held high.
- memb_pot is registered and reflects each update the cycle after it occurs.
- step_ready, out_valid and out_spike are decoded from registered state/flags, with no combinational path from inputs.

## Structure
- Package pe_pkg holds:
  - the state enum lif_state_t
  - the function sat_add(v, w) that performs the clamp
  - localparam V_MAX/V_MIN derivation helpers
- Sub-module pe_weight_mem: N_IN×W_WIDTH register file, synchronous write, asynchronous read, reset to 0.
- FSM, accumulator, leak and refractory counter live in lif_pe.

## Test plan
All scenarios use N_IN=4, W_WIDTH=8, V_WIDTH=12, THRESHOLD=20, REFRACT=2 unless stated.
- Basic accumulate, LEAK_SHIFT=0, weights {5,10,3,7}:
  - Step with in_spikes=4'b0011 → out_valid at cycle 6, out_spike=0, memb_pot=15.
  - Repeat the step → out_spike=1, memb_pot=0.
- Leak, LEAK_SHIFT=2, weights {16,0,0,0}: in_spikes=4'b0001 → memb_pot=12, out_spike=0.
- Saturation, weights all −128, LEAK_SHIFT=0: five steps with 4'b1111 → memb_pot −512, −1024, −1536, −2048, −2048.
- Refractory: force a spike, then two steps with 4'b1111 and weights 5 → out_spike=0 and memb_pot=0 both times; third step → memb_pot=20, out_spike=0.
- Backpressure: hold out_ready=0 for 5 cycles in OUT → out_valid and out_spike stable, step_ready=0, and a concurrent step_valid is not accepted.
- Reset mid-ACCUM (cycle 2) → next cycle state IDLE, step_ready=1, out_valid=0, memb_pot=0, and all weights read back 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the LIF processing element.
//   lif_state_t : FSM state encoding (IDLE, ACCUM, LEAK, OUT)
//   v_max/v_min : clamp limits of a signed vw-bit membrane potential
//   sat_add     : v + w clamped to the signed vw-bit range (vw <= 31)
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LEAK  = 2'd2,
    OUT   = 2'd3
  } lif_state_t;

  function automatic int v_max(input int vw);
    return (1 << (vw - 1)) - 1;
  endfunction

  function automatic int v_min(input int vw);
    return -(1 << (vw - 1));
  endfunction

  // Sum is formed at 64 bits so the clamp decision never sees a wrapped value.
  function automatic int sat_add(input int v, input int w, input int vw);
    longint s;
    s = longint'(v) + longint'(w);
    if (s > longint'(v_max(vw)))
      return v_max(vw);
    else if (s < longint'(v_min(vw)))
      return v_min(vw);
    else
      return int'(s);
  endfunction

endpackage

// File: rtl/pe_weight_mem.sv
// Synaptic weight register file for one LIF neuron.
//   clock, reset : posedge clock, synchronous active-high reset (weights -> 0)
//   w_en/w_addr/w_data : synchronous write port
//   r_addr/r_data      : asynchronous read port; a write in the same cycle
//                        is not visible until the following cycle
module pe_weight_mem #(
  parameter int N_IN    = 8,
  parameter int W_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       w_en,
  input  logic [$clog2(N_IN)-1:0]    w_addr,
  input  logic signed [W_WIDTH-1:0]  w_data,
  input  logic [$clog2(N_IN)-1:0]    r_addr,
  output logic signed [W_WIDTH-1:0]  r_data
);

  logic signed [W_WIDTH-1:0] mem [N_IN];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) mem[i] <= '0;
    end else if (w_en) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/lif_pe.sv
// Leaky integrate-and-fire processing element.
// One timestep of N_IN input spikes is taken per step handshake; the weight of
// each active synapse is added serially (one synapse per cycle) into a
// saturating membrane potential, then a shift leak is applied, the potential
// is compared with THRESHOLD and a refractory counter is updated. The spike
// result is held on out_valid/out_spike until out_ready.
//   clock, reset          : posedge clock, synchronous active-high reset
//   weight_w_en/addr/in   : weight write port, accepted in every state
//   step_valid/step_ready : timestep handshake, in_spikes sampled on accept
//   out_valid/out_ready   : result handshake, out_spike valid with out_valid
//   memb_pot              : registered membrane potential
module lif_pe
  import pe_pkg::*;
#(
  parameter int N_IN       = 8,
  parameter int W_WIDTH    = 8,
  parameter int V_WIDTH    = 12,
  parameter int THRESHOLD  = 20,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       weight_w_en,
  input  logic [$clog2(N_IN)-1:0]    weight_addr,
  input  logic signed [W_WIDTH-1:0]  weight_in,
  input  logic                       step_valid,
  output logic                       step_ready,
  input  logic [N_IN-1:0]            in_spikes,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_spike,
  output logic signed [V_WIDTH-1:0]  memb_pot
);

  localparam int IDX_W = $clog2(N_IN);
  localparam int REF_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [IDX_W-1:0]          IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic signed [V_WIDTH-1:0] V_THR    = V_WIDTH'(THRESHOLD);

  lif_state_t                state, state_nxt;
  logic [IDX_W-1:0]          idx;
  logic [N_IN-1:0]           spikes_q;
  logic signed [V_WIDTH-1:0] v;
  logic signed [V_WIDTH-1:0] v_acc;
  logic signed [V_WIDTH-1:0] v_leak;
  logic [REF_W-1:0]          ref_cnt;
  logic                      spike_q;
  logic signed [W_WIDTH-1:0] w_rd;

  pe_weight_mem #(
    .N_IN    (N_IN),
    .W_WIDTH (W_WIDTH)
  ) u_wmem (
    .clock  (clock),
    .reset  (reset),
    .w_en   (weight_w_en),
    .w_addr (weight_addr),
    .w_data (weight_in),
    .r_addr (idx),
    .r_data (w_rd)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (step_valid)      state_nxt = ACCUM;
      ACCUM:   if (idx == IDX_LAST) state_nxt = LEAK;
      LEAK:                         state_nxt = OUT;
      OUT:     if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    v_acc = V_WIDTH'(sat_add(int'(v), int'(w_rd), V_WIDTH));
    // Subtracting v >>> s (s >= 1) moves v toward zero, so it cannot overflow.
    if (LEAK_SHIFT == 0) v_leak = v;
    else                 v_leak = v - (v >>> LEAK_SHIFT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= '0;
      spikes_q <= '0;
      v        <= '0;
      ref_cnt  <= '0;
      spike_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (step_valid) begin
            spikes_q <= in_spikes;
            idx      <= '0;
          end
        end
        ACCUM: begin
          // Refractory steps walk all synapses too, keeping latency fixed.
          if (spikes_q[idx] && ref_cnt == '0) v <= v_acc;
          idx <= idx + IDX_W'(1);
        end
        LEAK: begin
          if (v_leak > V_THR) begin
            spike_q <= 1'b1;
            v       <= '0;
            ref_cnt <= REF_W'(REFRACT);
          end else begin
            spike_q <= 1'b0;
            v       <= v_leak;
            if (ref_cnt != '0) ref_cnt <= ref_cnt - REF_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign step_ready = (state == IDLE);
  assign out_valid  = (state == OUT);
  assign out_spike  = spike_q;
  assign memb_pot   = v;

endmodule

// File: tb/tb_lif_pe.sv
module tb_lif_pe;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset;
  logic              weight_w_en;
  logic [1:0]        weight_addr;
  logic signed [7:0] weight_in;
  logic              step_valid;
  logic              step_ready;
  logic [3:0]        in_spikes;
  logic              out_valid;
  logic              out_ready;
  logic              out_spike;
  logic signed [11:0] memb_pot;

  logic              weight_w_en_l;
  logic [1:0]        weight_addr_l;
  logic signed [7:0] weight_in_l;
  logic              step_valid_l;
  logic              step_ready_l;
  logic [3:0]        in_spikes_l;
  logic              out_valid_l;
  logic              out_ready_l;
  logic              out_spike_l;
  logic signed [11:0] memb_pot_l;

  lif_pe #(.N_IN(4), .W_WIDTH(8), .V_WIDTH(12), .THRESHOLD(20),
           .LEAK_SHIFT(0), .REFRACT(2)) dut (
    .clock(clock), .reset(reset),
    .weight_w_en(weight_w_en), .weight_addr(weight_addr), .weight_in(weight_in),
    .step_valid(step_valid), .step_ready(step_ready), .in_spikes(in_spikes),
    .out_valid(out_valid), .out_ready(out_ready), .out_spike(out_spike),
    .memb_pot(memb_pot));

  lif_pe #(.N_IN(4), .W_WIDTH(8), .V_WIDTH(12), .THRESHOLD(20),
           .LEAK_SHIFT(2), .REFRACT(2)) dut_leak (
    .clock(clock), .reset(reset),
    .weight_w_en(weight_w_en_l), .weight_addr(weight_addr_l), .weight_in(weight_in_l),
    .step_valid(step_valid_l), .step_ready(step_ready_l), .in_spikes(in_spikes_l),
    .out_valid(out_valid_l), .out_ready(out_ready_l), .out_spike(out_spike_l),
    .memb_pot(memb_pot_l));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       spike;
    logic signed [11:0] pot;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    bit                rst;
    bit                wr;
    logic signed [7:0] w0, w1, w2, w3;
    logic [3:0]        sp;
    logic              es;
    int                ep;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mk(input bit rst, input bit wr, input int w0, input int w1,
                              input int w2, input int w3, input logic [3:0] sp,
                              input logic es, input int ep);
    vec_t r;
    r.rst = rst; r.wr = wr;
    r.w0 = 8'(w0); r.w1 = 8'(w1); r.w2 = 8'(w2); r.w3 = 8'(w3);
    r.sp = sp; r.es = es; r.ep = ep;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted result handshake pops one expectation.
  always begin
    @(negedge clock);
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", int'(out_valid), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_spike", int'(out_spike), int'(e.spike));
        check("memb_pot", int'(memb_pot), int'(e.pot));
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    step_valid = 1'b0; weight_w_en = 1'b0;
    step_valid_l = 1'b0; weight_w_en_l = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_w(input logic signed [7:0] w0, input logic signed [7:0] w1,
                        input logic signed [7:0] w2, input logic signed [7:0] w3);
    logic signed [7:0] ws [4];
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      weight_w_en = 1'b1; weight_addr = 2'(i); weight_in = ws[i];
    end
    @(negedge clock);
    weight_w_en = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    if (!out_valid) check("out_valid_wait", int'(out_valid), 1);
  endtask

  // Offers one step, records the expectation and returns cycles from the
  // accept cycle to the first cycle with out_valid.
  task automatic do_step(input logic [3:0] sp, input logic es, input int ep, output int lat);
    int n;
    n = 0;
    while (!step_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!step_ready) check("step_ready_wait", int'(step_ready), 1);
    in_spikes = sp; step_valid = 1'b1;
    exp_q.push_back('{spike: es, pot: 12'(ep)});
    @(negedge clock);
    step_valid = 1'b0;
    wait_out(lat);
    @(negedge clock);
  endtask

  task automatic step_leak(input logic [3:0] sp, output logic spk, output int pot);
    int n;
    n = 0;
    in_spikes_l = sp; step_valid_l = 1'b1;
    @(negedge clock);
    step_valid_l = 1'b0;
    while (!out_valid_l && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("leak_out_valid_wait", int'(out_valid_l), 1);
    spk = out_spike_l;
    pot = int'(memb_pot_l);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   n;
    int   seen;
    logic spk;
    int   pot;

    reset = 1'b1;
    weight_w_en = 1'b0; weight_addr = '0; weight_in = '0;
    step_valid = 1'b0; in_spikes = '0; out_ready = 1'b1;
    weight_w_en_l = 1'b0; weight_addr_l = '0; weight_in_l = '0;
    step_valid_l = 1'b0; in_spikes_l = '0; out_ready_l = 1'b1;

    tbl[0]  = mk(1, 1, -128, -128, -128, -128, 4'b1111, 1'b0, -512);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 4'b1111, 1'b0, -1024);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 4'b1111, 1'b0, -1536);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 4'b1111, 1'b0, -2048);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 4'b1111, 1'b0, -2048);
    tbl[5]  = mk(1, 1, 5, 10, 3, 7, 4'b0011, 1'b0, 15);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 4'b0011, 1'b1, 0);
    tbl[7]  = mk(0, 1, 5, 5, 5, 5, 4'b1111, 1'b0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 4'b1111, 1'b0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 4'b1111, 1'b0, 20);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 4'b0000, 1'b0, 20);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 4'b0100, 1'b1, 0);

    do_reset();
    check("rst_step_ready", int'(step_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_spike", int'(out_spike), 0);
    check("rst_memb_pot", int'(memb_pot), 0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) do_reset();
      if (tbl[i].wr) load_w(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].w3);
      do_step(tbl[i].sp, tbl[i].es, tbl[i].ep, lat);
      check($sformatf("latency_row%0d", i), lat, 6);
    end

    // Leak instance: 16 - (16>>>2) = 12; then 28 - 7 = 21 > 20 fires.
    @(negedge clock);
    weight_w_en_l = 1'b1; weight_addr_l = 2'd0; weight_in_l = 8'sd16;
    @(negedge clock);
    weight_w_en_l = 1'b0;
    step_leak(4'b0001, spk, pot);
    check("leak_spike1", int'(spk), 0);
    check("leak_pot1", pot, 12);
    step_leak(4'b0001, spk, pot);
    check("leak_spike2", int'(spk), 1);
    check("leak_pot2", pot, 0);

    // Write to synapse 0 during its accumulate cycle: old weight is used.
    do_reset();
    load_w(8'sd5, 8'sd5, 8'sd5, 8'sd5);
    in_spikes = 4'b0001; step_valid = 1'b1;
    exp_q.push_back('{spike: 1'b0, pot: 12'sd5});
    @(negedge clock);
    step_valid = 1'b0;
    weight_w_en = 1'b1; weight_addr = 2'd0; weight_in = 8'sd100;
    @(negedge clock);
    weight_w_en = 1'b0;
    wait_out(lat);
    @(negedge clock);
    do_step(4'b0001, 1'b1, 0, lat);

    // Backpressure: result held, no new step accepted while in OUT.
    do_reset();
    load_w(8'sd5, 8'sd5, 8'sd5, 8'sd5);
    out_ready = 1'b0;
    in_spikes = 4'b1111; step_valid = 1'b1;
    exp_q.push_back('{spike: 1'b0, pot: 12'sd20});
    @(negedge clock);
    step_valid = 1'b0;
    wait_out(lat);
    check("bp_latency", lat, 6);
    step_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_out_valid_%0d", k), int'(out_valid), 1);
      check($sformatf("bp_out_spike_%0d", k), int'(out_spike), 0);
      check($sformatf("bp_step_ready_%0d", k), int'(step_ready), 0);
      check($sformatf("bp_memb_pot_%0d", k), int'(memb_pot), 20);
      @(negedge clock);
    end
    step_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_idle_after", int'(step_ready), 1);
    check("bp_pot_after", int'(memb_pot), 20);

    // Reset during ACCUM discards the step and clears weights.
    do_reset();
    load_w(8'sd5, 8'sd5, 8'sd5, 8'sd5);
    in_spikes = 4'b1111; step_valid = 1'b1;
    @(negedge clock);
    step_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_step_ready", int'(step_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_memb_pot", int'(memb_pot), 0);
    reset = 1'b0;
    seen = 0;
    for (n = 0; n < 10; n++) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    check("midrst_no_result", seen, 0);
    do_step(4'b1111, 1'b0, 0, lat);
    check("midrst_weights_zero_latency", lat, 6);

    repeat (2) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
